// File: rtl/rv_commit_trace_buffer.sv
// Commit trace capture for the RV64 single-cycle core: records {pc, instr, result}
// per retired instruction into a circular buffer around a trigger, then replays oldest-first.
module rv_commit_trace_buffer #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [ILEN-1:0] commit_instr,
  input  logic [XLEN-1:0] commit_result,
  input  logic            arm,
  input  logic [1:0]      trig_mode,
  input  logic [XLEN-1:0] trig_value,
  input  logic [CW-1:0]   post_count,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [ILEN-1:0] rd_instr,
  output logic [XLEN-1:0] rd_result,
  output logic [CW-1:0]   entries,
  output logic [1:0]      state,
  output logic            done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_POST    = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_mode;
  logic [XLEN-1:0] r_tval;
  logic [CW-1:0]   r_post;
  logic [CW-1:0]   r_post_cnt;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_entries;
  logic            r_done;

  logic [XLEN-1:0] r_pc_mem  [DEPTH];
  logic [ILEN-1:0] r_ins_mem [DEPTH];
  logic [XLEN-1:0] r_res_mem [DEPTH];

  logic            w_arm_take;
  logic            w_rec;
  logic            w_hit;
  logic            w_fire;
  logic            w_rd_valid;
  logic            w_hs;
  logic            w_last;
  logic [CW-1:0]   w_post_clip;
  logic [CW-1:0]   w_entries_nxt;
  logic [AW-1:0]   w_wptr_nxt;

  assign w_arm_take  = (r_state == S_IDLE) && arm;
  assign w_rec       = commit_valid && ((r_state == S_ARMED) || (r_state == S_POST));
  assign w_post_clip = (post_count > MAX_POST) ? MAX_POST : post_count;

  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      2'd0:    w_hit = 1'b1;
      2'd1:    w_hit = (commit_pc == r_tval);
      2'd2:    w_hit = (commit_instr == r_tval[ILEN-1:0]);
      default: w_hit = (commit_result == r_tval);
    endcase
  end

  assign w_fire = (r_state == S_ARMED) && commit_valid && w_hit;

  // Readout handshake: an entry transfers on a cycle where rd_valid and rd_ready are
  // both high; rd_valid never drops and rd_* never change until that transfer happens.
  assign w_rd_valid = (r_state == S_READOUT) && (r_entries != '0);
  assign w_hs       = w_rd_valid && rd_ready;
  assign w_last     = w_hs && (r_entries == ONE_C);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_fire) w_state_nxt = (r_post == '0) ? S_READOUT : S_POST;
      end
      S_POST: begin
        if (commit_valid && (r_post_cnt == ONE_C)) w_state_nxt = S_READOUT;
      end
      S_READOUT: begin
        if ((r_entries == '0) || w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_entries_nxt = r_entries;
    w_wptr_nxt    = r_wptr;
    if (w_arm_take) begin
      w_entries_nxt = '0;
      w_wptr_nxt    = '0;
    end else if (w_rec) begin
      w_wptr_nxt = r_wptr + AW'(1);
      if (r_entries != DEPTH_C) w_entries_nxt = r_entries + ONE_C;
    end else if (w_hs) begin
      w_entries_nxt = r_entries - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_tval     <= '0;
      r_post     <= '0;
      r_post_cnt <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_entries  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_entries <= w_entries_nxt;
      r_wptr    <= w_wptr_nxt;
      r_done    <= w_last;
      if (w_arm_take) begin
        r_mode <= trig_mode;
        r_tval <= trig_value;
        r_post <= w_post_clip;
        r_rptr <= '0;
      end
      if (w_fire) begin
        r_post_cnt <= r_post;
      end else if ((r_state == S_POST) && commit_valid) begin
        r_post_cnt <= r_post_cnt - ONE_C;
      end
      // Oldest entry sits entries slots behind the write pointer; a full buffer wraps to wptr.
      if ((r_state != S_READOUT) && (w_state_nxt == S_READOUT)) begin
        r_rptr <= w_wptr_nxt - w_entries_nxt[AW-1:0];
      end else if (w_hs) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rec && !reset) begin
      r_pc_mem[r_wptr]  <= commit_pc;
      r_ins_mem[r_wptr] <= commit_instr;
      r_res_mem[r_wptr] <= commit_result;
    end
  end

  assign rd_valid  = w_rd_valid;
  assign rd_pc     = r_pc_mem[r_rptr];
  assign rd_instr  = r_ins_mem[r_rptr];
  assign rd_result = r_res_mem[r_rptr];
  assign entries   = r_entries;
  assign state     = r_state;
  assign done      = r_done;

endmodule

// File: tb/tb_rv_commit_trace_buffer.sv
// Bench for rv_commit_trace_buffer (DEPTH=8): directed trigger scenarios plus a random
// soak, all compared every cycle against a queue-based model of the trace buffer.
module tb_rv_commit_trace_buffer;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = 2 * XLEN + ILEN;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            commit_valid = 1'b0;
  logic [XLEN-1:0] commit_pc = '0;
  logic [ILEN-1:0] commit_instr = '0;
  logic [XLEN-1:0] commit_result = '0;
  logic            arm = 1'b0;
  logic [1:0]      trig_mode = '0;
  logic [XLEN-1:0] trig_value = '0;
  logic [CW-1:0]   post_count = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [XLEN-1:0] rd_pc;
  logic [ILEN-1:0] rd_instr;
  logic [XLEN-1:0] rd_result;
  logic [CW-1:0]   entries;
  logic [1:0]      state;
  logic            done;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rv_commit_trace_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_result(commit_result),
    .arm(arm), .trig_mode(trig_mode), .trig_value(trig_value),
    .post_count(post_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result),
    .entries(entries), .state(state), .done(done)
  );

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0]   exp_q[$];
  int              m_state = 0;
  int              m_mode = 0;
  logic [XLEN-1:0] m_tval = '0;
  int              m_post = 0;
  int              m_cnt = 0;
  bit              m_done = 1'b0;
  bit              cmp_en = 1'b0;
  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] got_pc[$];
  logic [ILEN-1:0] got_instr[$];

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(int mode, logic [XLEN-1:0] tv, logic [XLEN-1:0] pc,
                             logic [ILEN-1:0] ins, logic [XLEN-1:0] res);
    case (mode)
      0:       return 1'b1;
      1:       return pc == tv;
      2:       return ins == tv[ILEN-1:0];
      default: return res == tv;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      got_pc.push_back(rd_pc);
      got_instr.push_back(rd_instr);
    end
    m_done = 1'b0;
    if (reset) begin
      m_state = 0;
      exp_q.delete();
    end else begin
      case (m_state)
        0: if (arm) begin
          m_mode  = int'(trig_mode);
          m_tval  = trig_value;
          m_post  = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
          exp_q.delete();
          m_state = 1;
        end
        1, 2: if (commit_valid) begin
          exp_q.push_back({commit_pc, commit_instr, commit_result});
          if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
          if (m_state == 1) begin
            if (hit(m_mode, m_tval, commit_pc, commit_instr, commit_result)) begin
              if (m_post == 0) m_state = 3;
              else begin
                m_cnt   = m_post;
                m_state = 2;
              end
            end
          end else begin
            m_cnt--;
            if (m_cnt == 0) m_state = 3;
          end
        end
        default: if (rd_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_state = 0;
            m_done  = 1'b1;
          end
        end
      endcase
    end
    cmp_en = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", EW'(state), EW'(m_state));
      chk("entries", EW'(entries), EW'(exp_q.size()));
      chk("rd_valid", EW'(rd_valid), EW'((m_state == 3) && (exp_q.size() > 0)));
      chk("done", EW'(done), EW'(m_done));
      if ((m_state == 3) && (exp_q.size() > 0))
        chk("rd_data", {rd_pc, rd_instr, rd_result}, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [XLEN-1:0] tv, input logic [CW-1:0] pc_n);
    arm = 1'b1; trig_mode = mode; trig_value = tv; post_count = pc_n;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_commit(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins,
                           input logic [XLEN-1:0] res);
    commit_valid = 1'b1; commit_pc = pc; commit_instr = ins; commit_result = res;
    tick();
    commit_valid = 1'b0;
  endtask

  // pat bit i%len is rd_ready on cycle i; len=0 means random ready
  task automatic do_readout(input logic [3:0] pat, input int len);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (len == 0) rd_ready = 1'($urandom_range(0, 1));
      else begin
        automatic logic [3:0] p = pat;
        rd_ready = p[i % len];
      end
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    rd_ready = 1'b0;
    chk("readout_done_seen", EW'(seen), EW'(1));
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_instr.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // 1: immediate trigger, post=3
    clear_got();
    do_arm(2'd0, '0, CW'(3));
    for (int i = 0; i < 4; i++) do_commit(XLEN'(4 * i), 32'h13, XLEN'($urandom));
    chk("t1_state", EW'(state), EW'(3));
    chk("t1_entries", EW'(entries), EW'(4));
    do_readout(4'b1111, 1);
    chk("t1_count", EW'(got_pc.size()), EW'(4));
    for (int i = 0; i < 4 && i < got_pc.size(); i++) chk("t1_pc", EW'(got_pc[i]), EW'(4 * i));

    // 2+3: PC match with wrap, readout stalled with ready 1,0,0,1
    clear_got();
    do_arm(2'd1, XLEN'('h20), CW'(2));
    for (int i = 0; i < 16; i++) do_commit(XLEN'(4 * i), 32'h33, XLEN'($urandom));
    chk("t2_entries", EW'(entries), EW'(8));
    do_readout(4'b1001, 4);
    chk("t2_count", EW'(got_pc.size()), EW'(8));
    for (int i = 0; i < 8 && i < got_pc.size(); i++) chk("t2_pc", EW'(got_pc[i]), EW'('hC + 4 * i));

    // 4: reset during POST, then re-arm on a result match
    do_arm(2'd0, '0, CW'(5));
    do_commit(XLEN'('h40), 32'h13, XLEN'(1));
    do_commit(XLEN'('h44), 32'h13, XLEN'(2));
    chk("t4_post", EW'(state), EW'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_state", EW'(state), EW'(0));
    chk("t4_entries", EW'(entries), EW'(0));
    chk("t4_rd_valid", EW'(rd_valid), EW'(0));
    clear_got();
    do_arm(2'd3, XLEN'('hDEAD), CW'(0));
    do_commit(XLEN'('h80), 32'h13, XLEN'($urandom_range(0, 1000)));
    do_commit(XLEN'('h84), 32'h13, XLEN'($urandom_range(0, 1000)));
    do_commit(XLEN'('h88), 32'h13, XLEN'('hDEAD));
    chk("t4_rearm_state", EW'(state), EW'(3));
    chk("t4_rearm_entries", EW'(entries), EW'(3));
    do_readout(4'b0000, 0);
    chk("t4_last_pc", EW'(got_pc.size() == 3 ? got_pc[2] : '0), EW'('h88));

    // 5: instr match, post clipped from 15 to 7, gaps not recorded
    clear_got();
    do_arm(2'd2, XLEN'('h13), CW'(15));
    for (int i = 0; i < 5; i++)
      do_commit(XLEN'('h10 + 4 * i), 32'h33 | ILEN'($urandom_range(1, 1000) << 7), XLEN'($urandom));
    do_commit(XLEN'('h100), 32'h13, XLEN'($urandom));
    for (int k = 0; k < 7; k++) begin
      while ($urandom_range(0, 1) == 1) tick();
      do_commit(XLEN'('h104 + 4 * k), 32'h33, XLEN'($urandom));
    end
    chk("t5_state", EW'(state), EW'(3));
    chk("t5_entries", EW'(entries), EW'(8));
    do_commit(XLEN'('h200), 32'h13, '0);
    do_readout(4'b0000, 0);
    chk("t5_count", EW'(got_pc.size()), EW'(8));
    chk("t5_first_instr", EW'(got_instr.size() > 0 ? got_instr[0] : '0), EW'('h13));
    chk("t5_last_pc", EW'(got_pc.size() == 8 ? got_pc[7] : '0), EW'('h11C));

    // 6: second arm while ARMED is ignored
    clear_got();
    do_arm(2'd1, XLEN'('h100), CW'(1));
    do_arm(2'd1, XLEN'('h8), CW'(0));
    chk("t6_armed", EW'(state), EW'(1));
    do_commit(XLEN'('h0), 32'h33, '0);
    do_commit(XLEN'('h4), 32'h33, '0);
    do_commit(XLEN'('h8), 32'h33, '0);
    do_commit(XLEN'('hC), 32'h33, '0);
    do_commit(XLEN'('h100), 32'h33, '0);
    do_commit(XLEN'('h104), 32'h33, '0);
    chk("t6_state", EW'(state), EW'(3));
    chk("t6_entries", EW'(entries), EW'(6));
    do_readout(4'b0110, 3);
    chk("t6_count", EW'(got_pc.size()), EW'(6));
    chk("t6_last_pc", EW'(got_pc.size() == 6 ? got_pc[5] : '0), EW'('h104));

    // random soak: small value pools so every trigger mode actually fires
    for (int n = 0; n < 4000; n++) begin
      reset         = ($urandom_range(0, 299) == 0);
      arm           = ($urandom_range(0, 3) == 0);
      trig_mode     = 2'($urandom_range(0, 3));
      trig_value    = XLEN'($urandom_range(0, 15) * 4);
      post_count    = CW'($urandom_range(0, 15));
      commit_valid  = 1'($urandom_range(0, 1));
      commit_pc     = XLEN'($urandom_range(0, 15) * 4);
      commit_instr  = ILEN'($urandom_range(0, 15) * 4);
      commit_result = XLEN'($urandom_range(0, 15) * 4);
      rd_ready      = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0; arm = 1'b0; commit_valid = 1'b0; rd_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
